// File: rtl/defines_pkg.sv
// Shared types for the inference engines.
//   dnn_state_t : sequencing states of the DNN engine.
//   mlp_state_t : sequencing states of the two-layer MLP engine.
//   idx_w()     : width of a counter that indexes 0..n-1 (never below 1 bit).
package defines_pkg;

  typedef enum logic [1:0] {
    DNN_IDLE,
    DNN_LOAD,
    DNN_RUN,
    DNN_DONE
  } dnn_state_t;

  typedef enum logic [1:0] {
    IDLE,
    L1,
    L2,
    DONE
  } mlp_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// Signed multiply-accumulate lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : zero the accumulator on this edge (wins over i_en)
//   i_en       : add i_a*i_b to the accumulator on this edge
//   i_a, i_b   : signed operands
//   o_acc_nxt  : value the accumulator takes on the coming edge, so the
//                caller can capture a finished sum on the same edge as the
//                final accumulate.
module mlp_mac_lane #(
  parameter int unsigned AW   = 7,
  parameter int unsigned BW   = 5,
  parameter int unsigned ACCW = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic signed [AW-1:0]   i_a,
  input  logic signed [BW-1:0]   i_b,
  output logic signed [ACCW-1:0] o_acc_nxt
);

  logic signed [AW+BW-1:0] w_prod;
  logic signed [ACCW-1:0]  w_acc_d;
  logic signed [ACCW-1:0]  r_acc;

  assign w_prod = i_a * i_b;

  always_comb begin
    w_acc_d = r_acc;
    if (i_clr) begin
      w_acc_d = '0;
    end else if (i_en) begin
      // Size cast of a signed product sign-extends into the accumulator.
      w_acc_d = r_acc + ACCW'(w_prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_d;
    end
  end

  assign o_acc_nxt = w_acc_d;

endmodule

// File: rtl/mlp_engine.sv
// Two-layer integer MLP: out = W2^T * ReLU(W1^T * x), one input feature per
// cycle in layer 1 and one hidden neuron per cycle in layer 2.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort back to IDLE (highest priority)
//   in_valid / in_ready : operand bundle handshake (accepted only in IDLE)
//   x_flat              : N_IN signed XW-bit inputs
//   w1_flat             : N_IN*N_HID signed WW-bit weights, w1[i][j] at i*N_HID+j
//   w2_flat             : N_HID*N_OUT signed WW-bit weights, w2[j][o] at j*N_OUT+o
//   out_valid/out_ready : result handshake (results held while in DONE)
//   out_flat            : N_OUT signed OW-bit results
module mlp_engine
  import defines_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_HID   = 4,
  parameter int unsigned N_OUT   = 2,
  parameter int unsigned XW      = 7,
  parameter int unsigned WW      = 5,
  parameter int unsigned HW      = 13,
  parameter int unsigned OW      = 21,
  parameter int unsigned HID_SAT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*XW-1:0]        x_flat,
  input  logic [N_IN*N_HID*WW-1:0]  w1_flat,
  input  logic [N_HID*N_OUT*WW-1:0] w2_flat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*OW-1:0]       out_flat
);

  localparam int unsigned A1W  = XW + WW + $clog2(N_IN);
  localparam int unsigned KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned KW   = idx_w(KMAX);
  // One spare bit so the hidden-sum reduction can see the sign of any value.
  localparam int unsigned EW   = ((A1W > HW) ? A1W : HW) + 1;

  localparam logic [KW-1:0] KLastIn  = KW'(N_IN - 1);
  localparam logic [KW-1:0] KLastHid = KW'(N_HID - 1);

  mlp_state_t r_state, w_state_d;
  logic [KW-1:0] r_k, w_k_d;

  logic [N_IN*XW-1:0]        r_x;
  logic [N_IN*N_HID*WW-1:0]  r_w1;
  logic [N_HID*N_OUT*WW-1:0] r_w2;
  logic [N_HID*HW-1:0]       r_h, w_h_d;
  logic [N_OUT*OW-1:0]       r_out, w_out_d;

  logic w_accept, w_l1_en, w_l2_en, w_l1_last, w_l2_last;
  logic [XW-1:0] w_xk;
  logic [HW-1:0] w_hk;

  assign w_accept  = (r_state == IDLE) && in_valid && !flush;
  assign w_l1_en   = (r_state == L1) && !flush;
  assign w_l2_en   = (r_state == L2) && !flush;
  assign w_l1_last = w_l1_en && (r_k == KLastIn);
  assign w_l2_last = w_l2_en && (r_k == KLastHid);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_d = L1;
          w_k_d     = '0;
        end
      end
      L1: begin
        if (r_k == KLastIn) begin
          w_state_d = L2;
          w_k_d     = '0;
        end else begin
          w_k_d = r_k + KW'(1);
        end
      end
      L2: begin
        if (r_k == KLastHid) begin
          w_state_d = DONE;
          w_k_d     = '0;
        end else begin
          w_k_d = r_k + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_k_d     = '0;
      end
    endcase
    if (flush) begin
      w_state_d = IDLE;
      w_k_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
    end
  end

  // ------------------------------------------------------ operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
    end else if (w_accept) begin
      r_x  <= x_flat;
      r_w1 <= w1_flat;
      r_w2 <= w2_flat;
    end
  end

  // Selects may run past the operand range when k counts the other layer;
  // the lanes are not enabled then.
  assign w_xk = r_x[r_k*XW +: XW];
  assign w_hk = r_h[r_k*HW +: HW];

  // ------------------------------------------------------------- layer 1
  for (genvar j = 0; j < N_HID; j++) begin : g_l1
    logic signed [A1W-1:0] w_acc1_nxt;
    logic signed [EW-1:0]  w_ext;
    logic [HW-1:0]         w_h_wrap, w_h_sat;

    mlp_mac_lane #(
      .AW   (XW),
      .BW   (WW),
      .ACCW (A1W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_accept),
      .i_en      (w_l1_en),
      .i_a       (w_xk),
      .i_b       (r_w1[(r_k*N_HID + j)*WW +: WW]),
      .o_acc_nxt (w_acc1_nxt)
    );

    assign w_ext = EW'(w_acc1_nxt);

    // Wrap: keep the low HW bits, then ReLU on the wrapped sign.
    assign w_h_wrap = w_ext[HW-1] ? '0 : w_ext[HW-1:0];

    // Saturate: negative -> 0; anything at or above 2^(HW-1) -> max positive.
    always_comb begin
      w_h_sat = w_ext[HW-1:0];
      if (w_ext[EW-1]) begin
        w_h_sat = '0;
      end else if (|w_ext[EW-2:HW-1]) begin
        w_h_sat = {1'b0, {(HW-1){1'b1}}};
      end
    end

    assign w_h_d[j*HW +: HW] = (HID_SAT != 0) ? w_h_sat : w_h_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
    end else if (w_l1_last) begin
      r_h <= w_h_d;
    end
  end

  // ------------------------------------------------------------- layer 2
  for (genvar o = 0; o < N_OUT; o++) begin : g_l2
    logic signed [OW-1:0] w_acc2_nxt;

    mlp_mac_lane #(
      .AW   (HW),
      .BW   (WW),
      .ACCW (OW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_accept),
      .i_en      (w_l2_en),
      .i_a       (w_hk),
      .i_b       (r_w2[(r_k*N_OUT + o)*WW +: WW]),
      .o_acc_nxt (w_acc2_nxt)
    );

    assign w_out_d[o*OW +: OW] = w_acc2_nxt;
  end

  // Results only change on a completed inference; flush leaves them intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_l2_last) begin
      r_out <= w_out_d;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_flat  = r_out;

endmodule
